// File: rtl/shift_reg_n_if.sv
// Bus bundle for shift_reg_n: load/shift/burst controls in, register state out.
// Parity exists only when SHIFT_REG_N_PARITY_EN is defined.
interface shift_reg_n_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             Load;
    logic [WIDTH-1:0] D;
    logic             Shift_En;
    logic             Shift_In;
    logic [1:0]       Mode;
    logic             Start;
    logic [CW-1:0]    Count;
    logic [WIDTH-1:0] A;
    logic             Shift_Out;
    logic             Busy;
    logic             Done;
`ifdef SHIFT_REG_N_PARITY_EN
    logic             Parity;
`endif

`ifdef SHIFT_REG_N_PARITY_EN
    modport master (
        output Load, D, Shift_En, Shift_In, Mode, Start, Count,
        input  A, Shift_Out, Busy, Done, Parity
    );

    modport slave (
        input  Load, D, Shift_En, Shift_In, Mode, Start, Count,
        output A, Shift_Out, Busy, Done, Parity
    );
`else
    modport master (
        output Load, D, Shift_En, Shift_In, Mode, Start, Count,
        input  A, Shift_Out, Busy, Done
    );

    modport slave (
        input  Load, D, Shift_En, Shift_In, Mode, Start, Count,
        output A, Shift_Out, Busy, Done
    );
`endif
endinterface

// File: rtl/shift_reg_n.sv
// WIDTH-bit load/shift register with four shift modes and a Count-shift burst sequencer.
// Optional registered Parity output enabled by defining SHIFT_REG_N_PARITY_EN.
module shift_reg_n #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic         Clk,
    input  logic         Reset,
    shift_reg_n_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       so_mode_s;
    logic             shift_out_s;

    function automatic logic [WIDTH-1:0] shift_fn(
        input logic [WIDTH-1:0] a,
        input logic [1:0]       mode,
        input logic             si
    );
        logic [WIDTH-1:0] r;
        case (mode)
            2'b00:   r = {si, a[WIDTH-1:1]};
            2'b01:   r = {a[WIDTH-1], a[WIDTH-1:1]};
            2'b10:   r = {a[WIDTH-2:0], si};
            2'b11:   r = {a[0], a[WIDTH-1:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic parity_fn(input logic [WIDTH-1:0] a);
        return ^a;
    endfunction

    // Next-state, next-register-value and burst bookkeeping
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Load) begin
                    a_d = bus.D;
                end else if (bus.Start) begin
                    mode_d = bus.Mode;
                    if (bus.Count != {CW{1'b0}}) begin
                        // first burst shift happens on the Start edge itself
                        a_d   = shift_fn(a_q, bus.Mode, bus.Shift_In);
                        rem_d = bus.Count - CW'(1);
                        if (bus.Count > CW'(1)) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end else begin
                        rem_d   = {CW{1'b0}};
                        state_d = ST_FIN;
                    end
                end else if (bus.Shift_En) begin
                    a_d = shift_fn(a_q, bus.Mode, bus.Shift_In);
                end else begin
                    a_d = a_q;
                end
            end
            ST_RUN: begin
                if (bus.Load) begin
                    a_d     = bus.D;
                    rem_d   = {CW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    a_d   = shift_fn(a_q, mode_q, bus.Shift_In);
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FIN: begin
                if (bus.Load) begin
                    a_d   = bus.D;
                    rem_d = {CW{1'b0}};
                end else begin
                    a_d = a_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = {CW{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State, data and status registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            rem_q   <= {CW{1'b0}};
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Shift_Out reflects the mode the next shift will use: latched mid-burst, live otherwise
    always_comb begin
        so_mode_s   = bus.Mode;
        shift_out_s = a_q[0];
        if (state_q == ST_RUN) begin
            so_mode_s = mode_q;
        end else begin
            so_mode_s = bus.Mode;
        end
        if (so_mode_s == 2'b10) begin
            shift_out_s = a_q[WIDTH-1];
        end else begin
            shift_out_s = a_q[0];
        end
    end

    assign bus.A         = a_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Shift_Out = shift_out_s;

`ifdef SHIFT_REG_N_PARITY_EN
    logic parity_q, parity_d;

    // Parity tracks the value A takes on the same edge
    always_comb begin
        parity_d = parity_fn(a_d);
    end

    // Parity register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.Parity = parity_q;
`endif

endmodule
